uart_word_bridge: RTL and testbench
===================================

Name: uart_word_bridge

Overview:
- Client-side partner of the UART peripheral's byte/FIFO interface; sits between a 32-bit word datapath and the UART.
- TX path: accepts words (valid/ready), splits LSB-byte-first into bytes, writes each into the UART TX FIFO with the i_tx_req / o_tx_rdy handshake.
- RX path: pops bytes from the UART RX FIFO with the i_rx_req / o_rx_rdy handshake and packs them LSB-first into words presented valid/ready.
- Both paths run independently in i_clk.

Parameters:
- BytesPerWord, 4: bytes per word; must be ≥2. WordWidth = 8*BytesPerWord.
- TimeoutCycles, 8680: i_clk cycles allowed between RX bytes of one partial word. Used only with the optional feature.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_tx_word  in  WordWidth  word to transmit
- i_tx_valid  in  1  i_tx_word valid
- o_tx_ready  out  1  bridge can accept a word
- o_tx_byte  out  8  byte to the UART (drives UART i_tx_data)
- o_tx_req  out  1  one-cycle write strobe to the UART TX FIFO
- i_tx_rdy  in  1  UART TX FIFO not full
- i_rx_byte  in  8  byte from the UART (UART o_rx_data)
- o_rx_req  out  1  one-cycle read strobe to the UART RX FIFO
- i_rx_rdy  in  1  UART RX FIFO not empty
- o_rx_word  out  WordWidth  assembled word
- o_rx_valid  out  1  o_rx_word valid
- i_rx_ready  in  1  consumer accepts word
- o_timeout_err  out  1  sticky RX inter-byte timeout flag
- i_err_clr  in  1  clears o_timeout_err
- o_busy  out  1  TX not idle OR RX holds a partial or full word

Behaviour:
- Reset:
  - All state goes to idle.
  - o_tx_ready=1, o_tx_req=0, o_tx_byte=0, o_rx_req=0, o_rx_valid=0, o_rx_word=0, o_timeout_err=0, o_busy=0.
  - Byte counters and shift registers clear. A reset mid-word discards the partial word, with no further strobes.
- TX FSM {TX_IDLE, TX_SEND}:
  - TX_IDLE: o_tx_ready=1. When i_tx_valid & o_tx_ready, load the shift register, set tx_cnt=0, go to TX_SEND.
  - TX_SEND: o_tx_ready=0; o_tx_byte = shreg[7:0].
  - o_tx_req = (state==TX_SEND) & i_tx_rdy. This is combinational from i_tx_rdy; never assert o_tx_req while i_tx_rdy=0.
  - Each strobe shifts the register right by 8 and increments tx_cnt.
  - The strobe with tx_cnt==BytesPerWord-1 returns to TX_IDLE. A new word can be accepted on the following cycle.
  - Back-to-back strobes are allowed while i_tx_rdy stays high: one word every BytesPerWord+1 cycles.
  - i_tx_rdy low stalls in place with the byte held.
- RX FSM {RX_WAIT, RX_CAP, RX_OUT}:
  - RX_WAIT: o_rx_req = i_rx_rdy (one-cycle pulse); a strobe goes to RX_CAP.
  - RX_CAP: FIFO read data is valid the cycle after the strobe.
    - shreg = {i_rx_byte, shreg[WordWidth-1:8]}; rx_cnt++.
    - If rx_cnt was BytesPerWord-1, go to RX_OUT, else RX_WAIT.
    - No o_rx_req in RX_CAP, so a stale i_rx_rdy cannot cause a double read. Peak rate is 1 byte per 2 cycles.
  - RX_OUT: o_rx_valid=1 and o_rx_word=shreg, held stable until i_rx_ready.
    - On i_rx_ready: o_rx_valid drops the next cycle, rx_cnt=0, go to RX_WAIT.
    - No bytes are popped in RX_OUT; UART FIFO backpressure applies upstream.
- Counters are $clog2(BytesPerWord) bits wide. There is no wrap beyond BytesPerWord-1.
- o_busy = (tx_state!=TX_IDLE) | (rx_cnt!=0) | (rx_state!=RX_WAIT).

Optional Feature:
- Macro: UART_WORD_BRIDGE_TIMEOUT_EN.
- With the macro defined, the timeout is enabled:
  - A $clog2(TimeoutCycles)-bit counter runs in RX_WAIT while rx_cnt!=0, and clears on every RX_CAP and whenever rx_cnt==0.
  - When it reaches TimeoutCycles-1: rx_cnt=0, the partial word is discarded (shreg cleared), the counter clears, and o_timeout_err is set.
  - o_timeout_err stays set until i_err_clr. If set and clear occur in the same cycle, set wins.
  - The timeout never fires in RX_OUT or with rx_cnt==0.
- Without the macro: no counter is instantiated, o_timeout_err is tied 0, i_err_clr is ignored, and partial words wait indefinitely.

Decomposition:
- uart_pkg holds:
  - BYTE_W=8;
  - typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
  - typedef enum logic [1:0] {RX_WAIT, RX_CAP, RX_OUT} rx_state_e.
- Single module with no sub-module. The TX and RX paths are separate always_ff blocks in one file (about 200 lines).

Test Plan:
- TX basic: i_tx_word=0xDEADBEEF, i_tx_rdy=1 → o_tx_req pulses on 4 consecutive cycles with bytes EF, BE, AD, DE; o_tx_ready returns 1 the cycle after the 4th.
- TX stall: same word, i_tx_rdy=0 for 5 cycles after byte 2 → no strobe while low, o_tx_byte holds 0xAD, then AD and DE are sent; no byte is lost or duplicated.
- RX basic: a FIFO model supplies 0x11, 0x22, 0x33, 0x44 → o_rx_req pulses 4 times, never in consecutive cycles; o_rx_valid=1 with o_rx_word=0x44332211.
- RX backpressure: i_rx_ready=0 for 10 cycles while 4 more bytes wait → o_rx_word stays stable, no o_rx_req; after accept, the next word 0x88776655 is assembled.
- Timeout (macro on, TimeoutCycles=16): 2 bytes, then the FIFO stays empty for 16 cycles → o_timeout_err=1 and rx_cnt=0; next bytes 01, 02, 03, 04 give 0x04030201. i_err_clr clears the flag. Macro off: flag stays 0.
- Reset mid-op: assert i_rst_n low after TX byte 2 and RX byte 3 → all outputs at reset values; after release no residual strobes, and a fresh word transfers correctly.

Source files
------------

// File: rtl/uart_word_bridge_pkg.sv
// Shared types and constants for the UART word bridge.
package uart_word_bridge_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_WAIT,
        RX_CAP,
        RX_OUT
    } rx_state_e;

    function automatic int word_width(input int bytes_per_word);
        return bytes_per_word * BYTE_W;
    endfunction

endpackage

// File: rtl/uart_word_bridge_if.sv
// Word-side and UART-FIFO-side signals of the word bridge.
// The slave modport is the bridge; the master modport is its environment.
interface uart_word_bridge_if #(
    parameter int BytesPerWord = 4
);
    import uart_word_bridge_pkg::*;

    localparam int WordWidth = word_width(BytesPerWord);

    // word TX side
    logic [WordWidth-1:0] tx_word;
    logic                 tx_valid;
    logic                 tx_ready;
    // UART TX FIFO side
    logic [BYTE_W-1:0]    tx_byte;
    logic                 tx_req;
    logic                 tx_rdy;
    // UART RX FIFO side
    logic [BYTE_W-1:0]    rx_byte;
    logic                 rx_req;
    logic                 rx_rdy;
    // word RX side
    logic [WordWidth-1:0] rx_word;
    logic                 rx_valid;
    logic                 rx_ready;
    // status
    logic                 timeout_err;
    logic                 err_clr;
    logic                 busy;

    modport slave (
        input  tx_word, tx_valid, tx_rdy, rx_byte, rx_rdy, rx_ready, err_clr,
        output tx_ready, tx_byte, tx_req, rx_req, rx_word, rx_valid, timeout_err, busy
    );

    modport master (
        output tx_word, tx_valid, tx_rdy, rx_byte, rx_rdy, rx_ready, err_clr,
        input  tx_ready, tx_byte, tx_req, rx_req, rx_word, rx_valid, timeout_err, busy
    );

endinterface

// File: rtl/uart_word_bridge.sv
// Splits words into UART TX FIFO bytes and packs UART RX FIFO bytes into words (LSB first).
// Define UART_WORD_BRIDGE_TIMEOUT_EN to enable the RX inter-byte timeout and its sticky flag.
module uart_word_bridge
    import uart_word_bridge_pkg::*;
#(
    parameter int BytesPerWord  = 4,
    parameter int TimeoutCycles = 8680
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    uart_word_bridge_if.slave bus
);

    localparam int WordWidth = word_width(BytesPerWord);
    localparam int CntW      = $clog2(BytesPerWord);
    localparam logic [CntW-1:0] LastIdx = CntW'(BytesPerWord - 1);

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_e            tx_state_reg;
    logic [WordWidth-1:0] tx_shreg_reg;
    logic [CntW-1:0]      tx_cnt_reg;
    logic                 tx_strobe;

    // The write strobe follows i_tx_rdy combinationally so a full FIFO is never written.
    assign tx_strobe = (tx_state_reg == TX_SEND) && bus.tx_rdy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state_reg <= TX_IDLE;
            tx_shreg_reg <= '0;
            tx_cnt_reg   <= '0;
        end else begin
            case (tx_state_reg)
                TX_IDLE: begin
                    if (bus.tx_valid) begin
                        tx_shreg_reg <= bus.tx_word;
                        tx_cnt_reg   <= '0;
                        tx_state_reg <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (bus.tx_rdy) begin
                        tx_shreg_reg <= {BYTE_W'(0), tx_shreg_reg[WordWidth-1:BYTE_W]};
                        if (tx_cnt_reg == LastIdx) begin
                            tx_cnt_reg   <= '0;
                            tx_state_reg <= TX_IDLE;
                        end else begin
                            tx_cnt_reg <= tx_cnt_reg + CntW'(1);
                        end
                    end
                end
                default: tx_state_reg <= TX_IDLE;
            endcase
        end
    end

    assign bus.tx_ready = (tx_state_reg == TX_IDLE);
    assign bus.tx_byte  = tx_shreg_reg[BYTE_W-1:0];
    assign bus.tx_req   = tx_strobe;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    rx_state_e            rx_state_reg;
    logic [WordWidth-1:0] rx_shreg_reg;
    logic [CntW-1:0]      rx_cnt_reg;
    logic                 rx_strobe;
    logic                 tmo_fire;

    assign rx_strobe = (rx_state_reg == RX_WAIT) && bus.rx_rdy;

`ifdef UART_WORD_BRIDGE_TIMEOUT_EN
    localparam int TmoW = $clog2(TimeoutCycles);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    logic [TmoW-1:0] tmo_cnt_reg;
    logic            timeout_err_reg;

    assign tmo_fire = (rx_state_reg == RX_WAIT) && (rx_cnt_reg != '0) && (tmo_cnt_reg == TmoLast);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt_reg     <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            // Only idle gaps inside a partial word are timed.
            if ((rx_state_reg != RX_WAIT) || (rx_cnt_reg == '0) || tmo_fire) begin
                tmo_cnt_reg <= '0;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + TmoW'(1);
            end
            // A new timeout outranks a simultaneous clear.
            if (tmo_fire) begin
                timeout_err_reg <= 1'b1;
            end else if (bus.err_clr) begin
                timeout_err_reg <= 1'b0;
            end
        end
    end

    assign bus.timeout_err = timeout_err_reg;
`else
    localparam int unused_timeout_cycles = TimeoutCycles;
    logic unused_err_clr;

    assign unused_err_clr  = bus.err_clr;
    assign tmo_fire        = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state_reg <= RX_WAIT;
            rx_shreg_reg <= '0;
            rx_cnt_reg   <= '0;
        end else begin
            case (rx_state_reg)
                RX_WAIT: begin
                    // A byte popped in the same cycle as a timeout starts the next word.
                    if (tmo_fire) begin
                        rx_cnt_reg   <= '0;
                        rx_shreg_reg <= '0;
                    end
                    if (bus.rx_rdy) begin
                        rx_state_reg <= RX_CAP;
                    end
                end
                RX_CAP: begin
                    rx_shreg_reg <= {bus.rx_byte, rx_shreg_reg[WordWidth-1:BYTE_W]};
                    if (rx_cnt_reg == LastIdx) begin
                        rx_state_reg <= RX_OUT;
                    end else begin
                        rx_cnt_reg   <= rx_cnt_reg + CntW'(1);
                        rx_state_reg <= RX_WAIT;
                    end
                end
                RX_OUT: begin
                    if (bus.rx_ready) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= RX_WAIT;
                    end
                end
                default: rx_state_reg <= RX_WAIT;
            endcase
        end
    end

    assign bus.rx_req   = rx_strobe;
    assign bus.rx_valid = (rx_state_reg == RX_OUT);
    assign bus.rx_word  = rx_shreg_reg;
    assign bus.busy     = (tx_state_reg != TX_IDLE) || (rx_cnt_reg != '0) || (rx_state_reg != RX_WAIT);

endmodule

// File: tb/tb_uart_word_bridge.sv
// Self-checking bench for uart_word_bridge: byte/word scoreboards fed by UART FIFO models.
module tb_uart_word_bridge;
    import uart_word_bridge_pkg::*;

    localparam int BPW = 4;
    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_word_bridge_if #(.BytesPerWord(BPW)) bus ();

    uart_word_bridge #(
        .BytesPerWord (BPW),
        .TimeoutCycles(TMO)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // environment knobs and scoreboards
    logic        tx_rdy_en   = 1'b1;
    logic        rx_ready_en = 1'b1;
    logic [7:0]  rx_fifo[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_rx[$];
    logic [7:0]  rx_pending  = 8'h00;
    logic        prev_rx_req = 1'b0;
    int          tx_sent     = 0;
    int          rx_popped   = 0;
    int          rx_words    = 0;

    // UART FIFO models and output monitor: drive at negedge, sample 1 time unit later.
    initial begin
        bus.tx_rdy   = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.rx_rdy   = 1'b0;
        bus.rx_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.tx_rdy   = tx_rdy_en;
            bus.rx_byte  = rx_pending;
            bus.rx_rdy   = (rx_fifo.size() > 0);
            bus.rx_ready = rx_ready_en;
            #1;
            if (rst_n) begin
                if (!bus.tx_rdy) check_eq("tx_req_gated", 32'(bus.tx_req), 32'h0);
                if (exp_tx.size() == 0) begin
                    check_eq("tx_unexpected_req", 32'(bus.tx_req), 32'h0);
                end else if (bus.tx_req) begin
                    $display("tx byte 0x%02h", bus.tx_byte);
                    check_eq("tx_byte", 32'(bus.tx_byte), 32'(exp_tx.pop_front()));
                    tx_sent++;
                end else if (!bus.tx_ready) begin
                    check_eq("tx_byte_hold", 32'(bus.tx_byte), 32'(exp_tx[0]));
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    for (int i = 0; i < BPW; i++) exp_tx.push_back(bus.tx_word[8*i +: 8]);
                end

                if (bus.rx_req) begin
                    check_eq("rx_req_gap", 32'(prev_rx_req), 32'h0);
                    check_eq("rx_req_needs_rdy", 32'(bus.rx_rdy), 32'h1);
                    if (rx_fifo.size() > 0) begin
                        rx_pending = rx_fifo.pop_front();
                        rx_popped++;
                    end
                end
                if (bus.rx_valid) begin
                    check_eq("rx_req_in_out", 32'(bus.rx_req), 32'h0);
                    if (exp_rx.size() == 0) begin
                        check_eq("rx_unexpected_valid", 32'(bus.rx_valid), 32'h0);
                    end else begin
                        check_eq("rx_word", bus.rx_word, exp_rx[0]);
                        if (bus.rx_ready) begin
                            $display("rx word 0x%08h accepted", bus.rx_word);
                            void'(exp_rx.pop_front());
                            rx_words++;
                        end
                    end
                end
                prev_rx_req = bus.rx_req;
            end else begin
                prev_rx_req = 1'b0;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok = 0;
        @(posedge clk);
        #1;
        bus.tx_word  = w;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #2;
            if (bus.tx_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("tx_accept_timeout", 32'(bus.tx_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        $display("tx word 0x%08h accepted", w);
    endtask

    task automatic wait_tx_sent(input int target);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (tx_sent >= target) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("tx_sent_timeout", 32'(tx_sent), 32'(target));
    endtask

    task automatic wait_tx_drained();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (exp_tx.size() == 0 && bus.tx_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("tx_drain_timeout", 32'(exp_tx.size()), 32'h0);
    endtask

    task automatic wait_rx_drained();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (exp_rx.size() == 0 && rx_fifo.size() == 0 && !bus.rx_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("rx_drain_timeout", 32'(exp_rx.size()), 32'h0);
    endtask

    task automatic push_rx_word(input logic [31:0] w, input bit expect_word);
        for (int i = 0; i < BPW; i++) rx_fifo.push_back(w[8*i +: 8]);
        if (expect_word) exp_rx.push_back(w);
    endtask

    initial begin
        int base;
        bit ok;
        logic [31:0] fresh;
        bus.tx_word  = '0;
        bus.tx_valid = 1'b0;
        bus.err_clr  = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_tx_ready", 32'(bus.tx_ready), 32'h1);
        check_eq("rst_tx_req", 32'(bus.tx_req), 32'h0);
        check_eq("rst_tx_byte", 32'(bus.tx_byte), 32'h0);
        check_eq("rst_rx_req", 32'(bus.rx_req), 32'h0);
        check_eq("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
        check_eq("rst_rx_word", bus.rx_word, 32'h0);
        check_eq("rst_timeout_err", 32'(bus.timeout_err), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(2);

        // TX basic: four back-to-back strobes, ready the cycle after the last
        send_word(32'hDEADBEEF);
        for (int i = 0; i < BPW; i++) begin
            @(negedge clk);
            #2;
            check_eq("tx_basic_req", 32'(bus.tx_req), 32'h1);
            check_eq("tx_basic_busy_ready", 32'(bus.tx_ready), 32'h0);
        end
        @(negedge clk);
        #2;
        check_eq("tx_basic_ready_back", 32'(bus.tx_ready), 32'h1);
        check_eq("tx_basic_idle_busy", 32'(bus.busy), 32'h0);
        check_eq("tx_basic_count", 32'(tx_sent), 32'd4);

        // TX stall: FIFO full for 5 cycles after byte 2
        base = tx_sent;
        send_word(32'hDEADBEEF);
        wait_tx_sent(base + 2);
        tx_rdy_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #2;
            check_eq("tx_stall_byte", 32'(bus.tx_byte), 32'hAD);
            check_eq("tx_stall_req", 32'(bus.tx_req), 32'h0);
        end
        tx_rdy_en = 1'b1;
        wait_tx_drained();
        check_eq("tx_stall_count", 32'(tx_sent), 32'(base + 4));

        // RX basic
        base = rx_words;
        push_rx_word(32'h44332211, 1'b1);
        wait_rx_drained();
        check_eq("rx_basic_words", 32'(rx_words), 32'(base + 1));

        // RX backpressure: word held while four more bytes wait in the FIFO
        rx_ready_en = 1'b0;
        push_rx_word(32'hCAFEF00D, 1'b1);
        push_rx_word(32'h88776655, 1'b1);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #2;
            if (bus.rx_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("rx_bp_valid_timeout", 32'(bus.rx_valid), 32'h1);
        repeat (10) begin
            @(negedge clk);
            #2;
            check_eq("rx_bp_no_req", 32'(bus.rx_req), 32'h0);
            check_eq("rx_bp_word", bus.rx_word, 32'hCAFEF00D);
            check_eq("rx_bp_valid", 32'(bus.rx_valid), 32'h1);
        end
        check_eq("rx_bp_fifo_level", 32'(rx_fifo.size()), 32'd4);
        rx_ready_en = 1'b1;
        wait_rx_drained();
        check_eq("rx_bp_words", 32'(rx_words), 32'(base + 3));

`ifdef UART_WORD_BRIDGE_TIMEOUT_EN
        // two bytes, then silence: partial word must be dropped after TMO idle cycles
        rx_fifo.push_back(8'hA1);
        rx_fifo.push_back(8'hA2);
        repeat (13) @(negedge clk);
        #2;
        check_eq("tmo_not_early", 32'(bus.timeout_err), 32'h0);
        check_eq("tmo_partial_busy", 32'(bus.busy), 32'h1);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #2;
            if (bus.timeout_err) begin
                ok = 1;
                break;
            end
        end
        check_eq("tmo_flag_set", 32'(bus.timeout_err), 32'h1);
        check_eq("tmo_partial_dropped", 32'(bus.busy), 32'h0);
        push_rx_word(32'h04030201, 1'b1);
        wait_rx_drained();
        check_eq("tmo_flag_sticky", 32'(bus.timeout_err), 32'h1);
        @(posedge clk);
        #1;
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        @(negedge clk);
        #2;
        check_eq("tmo_flag_cleared", 32'(bus.timeout_err), 32'h0);
`else
        // without the timeout a partial word waits indefinitely
        rx_fifo.push_back(8'hA1);
        rx_fifo.push_back(8'hA2);
        exp_rx.push_back(32'hA4A3A2A1);
        repeat (40) @(negedge clk);
        #2;
        check_eq("notmo_flag", 32'(bus.timeout_err), 32'h0);
        check_eq("notmo_partial_busy", 32'(bus.busy), 32'h1);
        check_eq("notmo_no_valid", 32'(bus.rx_valid), 32'h0);
        @(posedge clk);
        #1;
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        rx_fifo.push_back(8'hA3);
        rx_fifo.push_back(8'hA4);
        wait_rx_drained();
        check_eq("notmo_flag_after", 32'(bus.timeout_err), 32'h0);
`endif

        // reset in the middle of a TX word (after byte 2) and an RX word (after byte 3)
        base = rx_popped;
        rx_fifo.push_back(8'hB1);
        rx_fifo.push_back(8'hB2);
        rx_fifo.push_back(8'hB3);
        send_word(32'h12345678);
        wait_tx_sent(tx_sent - (tx_sent % BPW) + 2);
        tx_rdy_en = 1'b0;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #2;
            if (rx_popped >= base + 3) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("rst_rx_pop_timeout", 32'(rx_popped), 32'(base + 3));
        repeat (2) @(negedge clk);
        #2;
        check_eq("mid_busy", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        exp_tx.delete();
        rx_fifo.delete();
        exp_rx.delete();
        tx_rdy_en = 1'b1;
        #1;
        check_eq("midrst_tx_ready", 32'(bus.tx_ready), 32'h1);
        check_eq("midrst_tx_byte", 32'(bus.tx_byte), 32'h0);
        check_eq("midrst_rx_valid", 32'(bus.rx_valid), 32'h0);
        check_eq("midrst_rx_word", bus.rx_word, 32'h0);
        check_eq("midrst_busy", 32'(bus.busy), 32'h0);
        check_eq("midrst_timeout_err", 32'(bus.timeout_err), 32'h0);
        repeat (2) @(negedge clk);
        #2;
        check_eq("midrst_tx_req", 32'(bus.tx_req), 32'h0);
        check_eq("midrst_rx_req", 32'(bus.rx_req), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        wait_cycles(8);
        check_eq("post_rst_busy", 32'(bus.busy), 32'h0);

        // fresh transfer in both directions
        base  = tx_sent;
        fresh = 32'hA5C30F96;
        push_rx_word(fresh, 1'b1);
        send_word(fresh);
        wait_tx_drained();
        wait_rx_drained();
        check_eq("fresh_tx_count", 32'(tx_sent), 32'(base + 4));

        wait_cycles(4);
        check_eq("end_tx_queue", 32'(exp_tx.size()), 32'h0);
        check_eq("end_rx_queue", 32'(exp_rx.size()), 32'h0);
        check_eq("end_busy", 32'(bus.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
